flag_ram_writer: RTL and testbench
==================================

// Module: flag_ram_writer
// PURPOSE
//  Loads a frame of 1-bit sparsity flags into the flag RAM.
//  - Accepts packed IN_WIDTH-bit flag words over a valid/ready stream.
//  - Serialises each word into one single-bit RAM write per cycle, LSB first.
//  - Addresses increment from a start address and wrap modulo 2^ADDR_WIDTH.
//  - Sits between the flag fetch path and the flag RAM write port (write side of the flag RAM).
// PARAMETERS
//  IN_WIDTH    16  flags per input word; power of two, >= 2
//  ADDR_WIDTH  4   flag RAM address width; matches the RAM instance
// PORTS
//  clk        in   1               clock, all logic on rising edge
//  reset      in   1               synchronous, active-high
//  start      in   1               1-cycle pulse; begin a frame (sampled only in IDLE)
//  base_addr  in   ADDR_WIDTH      first RAM address of the frame, latched on start
//  num_flags  in   ADDR_WIDTH+1    flags in the frame, 0..2^ADDR_WIDTH, latched on start
//  in_valid   in   1               input flag word valid
//  in_data    in   IN_WIDTH        packed flags, bit 0 = first flag
//  in_ready   out  1               high only in LOAD
//  wr_req     out  1               RAM write strobe, 1 bit per cycle
//  wr_addr    out  ADDR_WIDTH      RAM write address
//  wr_data    out  1               RAM write data (current flag)
//  busy       out  1               state != IDLE
//  done       out  1               1-cycle pulse, frame complete
// BEHAVIOUR
//  Reset
//  - Next edge: state=IDLE; shift reg, counters, addr reg = 0.
//  - All outputs 0 (in_ready, wr_req, wr_addr, wr_data, busy, done).
//  - Reset mid-frame aborts the frame: no done, no further writes.
//  FSM states: IDLE, LOAD, SHIFT, DONE
//  - IDLE: start & num_flags!=0 -> LOAD; start & num_flags==0 -> DONE.
//    On start: latch base_addr -> addr reg and num_flags -> remain.
//  - LOAD: in_ready=1. On in_valid&in_ready: shreg<=in_data, bit_idx<=0, go SHIFT.
//    in_valid low leaves state unchanged; no writes.
//  - SHIFT, every cycle:
//    - Outputs: wr_req=1, wr_data=shreg[0], wr_addr=addr reg.
//    - Updates: shreg>>=1; addr+=1 (mod 2^ADDR_WIDTH); remain-=1; bit_idx+=1.
//    - Exit on remain==1 -> DONE; else bit_idx==IN_WIDTH-1 -> LOAD; else stay in SHIFT.
//  - DONE: done=1 for one cycle, then IDLE.
//  Outputs
//  - wr_req, wr_addr, wr_data, in_ready, busy and done are decoded from state registers only.
//    No combinational path from any input.
//  Timing
//  - Handshake in cycle k: first write in cycle k+1.
//  - Full word: IN_WIDTH consecutive writes.
//  - One bubble cycle (LOAD) between words.
//  - done in the cycle after the last write.
//  Boundaries
//  - Partial last word: unused high bits are discarded.
//  - num_flags > 2^ADDR_WIDTH: not supported; addresses wrap and overwrite.
//  - start while busy: ignored; latched base_addr/num_flags unaffected.
//  - start and reset in the same cycle: reset wins.
// TESTING (IN_WIDTH=16, ADDR_WIDTH=4 unless noted)
//  1. Full frame: base=0, num=16, word 0xA5C3.
//     -> 16 writes, addr 0..15, data 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
//     -> done the cycle after the addr-15 write.
//  2. Wrap: base=14, num=4, word 0x000F -> writes addr 14,15,0,1, all data=1; done next cycle.
//  3. Partial word (ADDR_WIDTH=5): base=0, num=20, words 0xFFFF then 0x00F0.
//     -> addr 0..15 data=1; 1-cycle in_ready bubble; addr 16..19 data=0.
//     -> no write to addr 20; in_ready stays 0 after the second handshake.
//  4. Zero length: start with num=0 -> done=1 on the next cycle.
//     -> in_ready and wr_req never assert; busy high for exactly 1 cycle.
//  5. Backpressure/ignored start: in_valid held low 5 cycles in LOAD -> in_ready=1, wr_req=0 throughout.
//     A second start during SHIFT -> write sequence and done timing unchanged.
//  6. Reset mid-SHIFT after 3 writes -> next cycle wr_req=0, busy=0, in_ready=0; done never pulses.

Source files
------------

// File: rtl/flag_ram_writer.sv
// Serialises packed flag words into one single-bit flag RAM write per cycle,
// LSB first, with addresses wrapping modulo 2^ADDR_WIDTH.
module flag_ram_writer #(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_flags,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  in_ready,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IDX_W = $clog2(IN_WIDTH);
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IN_WIDTH-1:0]   shreg;
  logic [IDX_W-1:0]      bit_idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      remain;

  // State register plus the frame datapath it sequences
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      addr_q  <= '0;
      remain  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q <= base_addr;
            remain <= num_flags;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            shreg   <= in_data;
            bit_idx <= '0;
          end
        end
        S_SHIFT: begin
          shreg   <= shreg >> 1;
          addr_q  <= addr_q + ADDR_WIDTH'(1);
          remain  <= remain - CNT_W'(1);
          bit_idx <= bit_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state: frame end takes priority over word end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_flags != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (remain == CNT_W'(1)) begin
          state_nxt = S_DONE;
        end else if (bit_idx == IDX_W'(IN_WIDTH - 1)) begin
          state_nxt = S_LOAD;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode state registers only; address/data are forced to 0 outside SHIFT
  always_comb begin
    in_ready = 1'b0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = 1'b0;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    case (state)
      S_LOAD: in_ready = 1'b1;
      S_SHIFT: begin
        wr_req  = 1'b1;
        wr_addr = addr_q;
        wr_data = shreg[0];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flag_ram_writer.sv
// Bench for flag_ram_writer: a 4-bit-address and a 5-bit-address instance, directed
// table frames, hand sequences for reset corners, and random frames against a frame model.
module tb_flag_ram_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start4, start5;
  logic [4:0]  base_addr;
  logic [5:0]  num_flags;
  logic        in_valid;
  logic [15:0] in_data;

  logic        in_ready4, wr_req4, wr_data4, busy4, done4;
  logic [3:0]  wr_addr4;
  logic        in_ready5, wr_req5, wr_data5, busy5, done5;
  logic [4:0]  wr_addr5;

  flag_ram_writer #(.IN_WIDTH(16), .ADDR_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .base_addr(base_addr[3:0]), .num_flags(num_flags[4:0]),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .wr_req(wr_req4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .busy(busy4), .done(done4)
  );

  flag_ram_writer #(.IN_WIDTH(16), .ADDR_WIDTH(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start5),
    .base_addr(base_addr), .num_flags(num_flags),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready5),
    .wr_req(wr_req5), .wr_addr(wr_addr5), .wr_data(wr_data5),
    .busy(busy5), .done(done5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Observation of whichever instance is selected
  bit         sel = 1'b0;
  logic       m_ready, m_wr, m_data, m_busy, m_done;
  logic [4:0] m_addr;
  always_comb begin
    m_ready = sel ? in_ready5 : in_ready4;
    m_wr    = sel ? wr_req5   : wr_req4;
    m_data  = sel ? wr_data5  : wr_data4;
    m_busy  = sel ? busy5     : busy4;
    m_done  = sel ? done5     : done4;
    m_addr  = sel ? wr_addr5  : {1'b0, wr_addr4};
  end

  typedef struct {
    int addr;
    int data;
    int c;
  } wr_t;

  wr_t         wq[$];
  int          hq[$];
  int          dq[$];
  int          busy_n;
  int          ready_n;
  logic [15:0] words_q[$];

  always @(negedge clk) begin
    if (m_wr) wq.push_back('{int'(m_addr), int'(m_data), cyc});
    if (m_done) dq.push_back(cyc);
    if (in_valid && m_ready) hq.push_back(cyc);
    if (m_busy) busy_n++;
    if (m_ready) ready_n++;
  end

  // One frame: drive start and words, then compare against the frame model.
  task automatic run_frame(input bit s, input int base, input int num, input int gap0,
                           input int gapmax, input bit poke,
                           output int n_wr, output int last, output int ones);
    int aw, nw, sc, to, g, exp_done, hs_ok;
    aw = s ? 5 : 4;
    nw = (num + 15) / 16;
    sel = s;
    wq.delete(); hq.delete(); dq.delete();
    busy_n = 0; ready_n = 0;
    @(posedge clk); #1;
    base_addr = 5'(base);
    num_flags = 6'(num);
    if (s) start5 = 1'b1; else start4 = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    start4 = 1'b0; start5 = 1'b0;
    for (int w = 0; w < nw; w++) begin
      g = (w == 0) ? gap0 : int'($urandom_range(gapmax, 0));
      for (int i = 0; i < g; i++) begin
        if (w == 0) begin
          @(negedge clk);
          chk("bp_in_ready", int'(m_ready), 1);
          chk("bp_wr_req", int'(m_wr), 0);
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = words_q[w];
      hs_ok = 0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (m_ready) begin
          hs_ok = 1;
          break;
        end
      end
      chk("handshake_seen", hs_ok, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      if (poke && w == 0) begin
        base_addr = 5'd9;
        num_flags = 6'd3;
        if (s) start5 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; start5 = 1'b0;
      end
    end
    to = 0;
    while (dq.size() == 0 && to < 200) begin
      @(posedge clk); #1;
      to++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("done_count", dq.size(), 1);
    chk("write_count", wq.size(), num);
    chk("handshake_count", hq.size(), nw);
    for (int i = 0; i < wq.size() && i < num; i++) begin
      chk("wr_addr", wq[i].addr, (base + i) % (1 << aw));
      chk("wr_data", wq[i].data, int'(words_q[i / 16][i % 16]));
      if (i / 16 < hq.size()) chk("wr_cycle", wq[i].c, hq[i / 16] + 1 + (i % 16));
    end
    if (num == 0) begin
      exp_done = sc + 1;
      chk("zero_busy_cycles", busy_n, 1);
      chk("zero_ready_cycles", ready_n, 0);
    end else if (hq.size() == nw) begin
      exp_done = hq[nw - 1] + 1 + ((num - 1) % 16) + 1;
    end else begin
      exp_done = -1;
    end
    if (dq.size() > 0) chk("done_cycle", dq[0], exp_done);
    n_wr = wq.size();
    last = (wq.size() > 0) ? wq[wq.size() - 1].addr : 0;
    ones = 0;
    foreach (wq[i]) ones += wq[i].data;
  endtask

  typedef struct {
    bit          s;
    int          base;
    int          num;
    logic [15:0] w0;
    logic [15:0] w1;
    int          gap0;
    bit          poke;
    int          exp_n;
    int          exp_last;
    int          exp_ones;
  } vec_t;

  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, last, ones, hs_ok;
    vt[0] = '{1'b0, 0,  16, 16'hA5C3, 16'h0000, 0, 1'b0, 16, 15, 8};
    vt[1] = '{1'b0, 14, 4,  16'h000F, 16'h0000, 0, 1'b0, 4,  1,  4};
    vt[2] = '{1'b1, 0,  20, 16'hFFFF, 16'h00F0, 0, 1'b0, 20, 19, 16};
    vt[3] = '{1'b0, 0,  0,  16'h0000, 16'h0000, 0, 1'b0, 0,  0,  0};
    vt[4] = '{1'b0, 3,  16, 16'h8001, 16'h0000, 5, 1'b1, 16, 2,  2};
    vt[5] = '{1'b1, 30, 5,  16'h0015, 16'h0000, 0, 1'b0, 5,  2,  3};

    reset = 1'b1; start4 = 1'b0; start5 = 1'b0;
    base_addr = '0; num_flags = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs4", int'({in_ready4, wr_req4, wr_addr4, wr_data4, busy4, done4}), 0);
    chk("rst_outputs5", int'({in_ready5, wr_req5, wr_addr5, wr_data5, busy5, done5}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vt[v]) begin
      words_q.delete();
      words_q.push_back(vt[v].w0);
      words_q.push_back(vt[v].w1);
      run_frame(vt[v].s, vt[v].base, vt[v].num, vt[v].gap0, 0, vt[v].poke, n, last, ones);
      chk($sformatf("vec%0d_writes", v), n, vt[v].exp_n);
      chk($sformatf("vec%0d_last_addr", v), last, vt[v].exp_last);
      chk($sformatf("vec%0d_ones", v), ones, vt[v].exp_ones);
      chk($sformatf("vec%0d_ready_cycles", v), ready_n,
          (vt[v].num == 0) ? 0 : vt[v].gap0 + (vt[v].num + 15) / 16);
    end

    // Reset after three writes of a frame aborts it
    sel = 1'b0;
    wq.delete(); dq.delete();
    @(posedge clk); #1;
    base_addr = 5'd0; num_flags = 6'd16; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    in_valid = 1'b1; in_data = 16'hFFFF;
    hs_ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready4) begin
        hs_ok = 1;
        break;
      end
    end
    chk("rst_mid_handshake", hs_ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_wr_req", int'(wr_req4), 0);
    chk("rst_mid_busy", int'(busy4), 0);
    chk("rst_mid_in_ready", int'(in_ready4), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("rst_mid_writes", wq.size(), 3);
    chk("rst_mid_no_done", dq.size(), 0);

    // Start coinciding with reset is dropped
    reset = 1'b1; start4 = 1'b1; num_flags = 6'd5;
    @(posedge clk); #1;
    reset = 1'b0; start4 = 1'b0;
    @(negedge clk);
    chk("start_with_reset_busy", int'(busy4), 0);
    chk("start_with_reset_ready", int'(in_ready4), 0);

    for (int it = 0; it < 40; it++) begin
      bit s;
      int num;
      s = (it % 4 == 3);
      num = int'($urandom_range(s ? 32 : 16, 0));
      words_q.delete();
      for (int w = 0; w < 2; w++) words_q.push_back(16'($urandom));
      run_frame(s, int'($urandom_range(s ? 31 : 15, 0)), num,
                int'($urandom_range(3, 0)), 3, 1'($urandom_range(1, 0)), n, last, ones);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
